btb_update_queue: RTL and testbench
===================================

// Module: btb_update_queue
//
// PURPOSE
// Staging queue between branch resolution (controller/branch unit) and the BTB
// write port. Buffers resolved mispredict updates, merges repeated updates to
// the same PC and drains at most one update per cycle into the BTB. Decouples
// the backend's resolution timing from the frontend's BTB write slot.
//
// PARAMETERS
// DEPTH  4  queue entries; power of two, >= 2
// CNT_W  8  width of saturating dropped-update counter
//
// PORTS
// clk_i         in   1      clock
// rst_ni        in   1      asynchronous reset, active low
// clr_i         in   1      synchronous clear, same effect as reset
// flush_i       in   1      discard all queued and in-flight updates
// debug_mode_i  in   1      high: new updates are ignored
// upd_valid_i   in   1      resolved-branch update valid
// upd_pc_i      in   VLEN   PC of the resolved branch (riscv::VLEN)
// upd_target_i  in   VLEN   resolved target address
// drain_en_i    in   1      BTB write slot available this cycle
// btb_update_o  out  struct ariane_pkg::btb_update_t {valid, pc, target_address}
// occupancy_o   out  $clog2(DEPTH)+1  valid entries held in the queue
// dropped_o     out  CNT_W  saturating count of updates lost to overflow
//
// BEHAVIOUR
// - Reset/clr_i: all entries invalid, head/tail pointers 0, btb_update_o all
//   zero, occupancy_o 0, dropped_o 0.
// - Storage: circular buffer, head (oldest) / tail pointers, per-entry valid,
//   pc, target. Invariant: no two valid entries hold the same pc.
// - Accept condition: upd_valid_i && !debug_mode_i && !flush_i.
// - Coalesce: accepted update whose pc equals (full VLEN compare) a valid entry
//   NOT being popped this cycle overwrites that entry's target in place; no
//   new entry, occupancy unchanged, FIFO order unchanged.
// - Enqueue: otherwise written at tail if not full, or if full and a pop
//   occurs in the same cycle (simultaneous push+pop on full is legal).
// - Overflow: full, no pop, no coalesce match -> update dropped, dropped_o +1,
//   saturating at 2^CNT_W-1. Queue contents unchanged.
// - Pop: when drain_en_i && queue non-empty, head entry removed at clock edge
//   and copied into output register; btb_update_o.valid = 1 for exactly the
//   following cycle, else btb_update_o.valid = 0 (pc/target hold last value).
// - Latency: update accepted in cycle N, queue empty, drain_en_i high ->
//   btb_update_o.valid in cycle N+2. One pop per cycle max -> sustained 1/cycle.
// - Empty + push same cycle: no bypass; entry visible for pop next cycle.
// - flush_i: at the edge all entries invalidated, pointers reset to 0,
//   btb_update_o.valid cleared; same-cycle input update and pop discarded.
//   dropped_o not cleared by flush.
// - debug_mode_i: blocks enqueue/coalesce only; draining continues.
// - occupancy_o: registered count, updated same edge as push/pop;
//   push+pop same cycle leaves it unchanged.
// - Pointer wrap: DEPTH power of two, pointers wrap modulo DEPTH; full/empty
//   disambiguated by occupancy counter.
//
// TESTING
// - Single update pc=0x80 tgt=0x200, drain_en_i=1 -> btb_update_o.valid in
//   cycle N+2 with pc=0x80 tgt=0x200, one cycle only; occupancy 1 then 0.
// - drain_en_i=0; updates pc 0x10,0x20,0x10(tgt 0x999) -> occupancy 2; drain
//   -> outputs 0x10/tgt 0x999 then 0x20, in that order.
// - drain_en_i=0, push DEPTH+3 distinct PCs -> occupancy DEPTH, dropped_o=3;
//   full + push + drain same cycle -> accepted, occupancy stays DEPTH.
// - Queue with 3 entries, flush_i pulse with concurrent upd_valid_i -> next
//   cycle occupancy 0, btb_update_o.valid 0, new update not stored.
// - debug_mode_i=1 with updates -> nothing enqueued, pending entries still drain.
// - rst_ni asserted mid-drain -> all outputs zero asynchronously; dropped_o
//   saturation check with CNT_W=2: 5 overflows -> dropped_o=3.

Source files
------------

// File: rtl/btb_update_queue.sv
// Staging queue between branch resolution and the BTB write port: coalesces
// repeated updates to one PC and drains at most one update per cycle.

package riscv;
  localparam int unsigned VLEN = 64;
endpackage

package ariane_pkg;
  typedef struct packed {
    logic                   valid;
    logic [riscv::VLEN-1:0] pc;
    logic [riscv::VLEN-1:0] target_address;
  } btb_update_t;
endpackage

module btb_update_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clr_i,
  input  logic                    flush_i,
  input  logic                    debug_mode_i,
  input  logic                    upd_valid_i,
  input  logic [riscv::VLEN-1:0]  upd_pc_i,
  input  logic [riscv::VLEN-1:0]  upd_target_i,
  input  logic                    drain_en_i,
  output ariane_pkg::btb_update_t btb_update_o,
  output logic [$clog2(DEPTH):0]  occupancy_o,
  output logic [CNT_W-1:0]        dropped_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0]       valid_q;
  logic [riscv::VLEN-1:0] pc_q  [DEPTH];
  logic [riscv::VLEN-1:0] tgt_q [DEPTH];
  logic [PTR_W-1:0]       head_q, tail_q;
  logic [PTR_W:0]         occ_q, occ_d;
  logic [CNT_W-1:0]       dropped_q;
  ariane_pkg::btb_update_t out_q;

  logic             accept, pop, full, hit, push, drop;
  logic [DEPTH-1:0] match;

  assign accept = upd_valid_i && !debug_mode_i && !flush_i;
  assign full   = (occ_q == (PTR_W+1)'(DEPTH));
  assign pop    = drain_en_i && (occ_q != '0) && !flush_i;

  // The entry leaving this cycle cannot absorb an update; it gets re-enqueued.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign match[gi] = accept && valid_q[gi] && (pc_q[gi] == upd_pc_i) &&
                       !(pop && (head_q == PTR_W'(gi)));
  end

  assign hit   = |match;
  assign push  = accept && !hit && (!full || pop);
  assign drop  = accept && !hit && full && !pop;
  assign occ_d = occ_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q   <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      occ_q     <= '0;
      dropped_q <= '0;
      out_q     <= '0;
    end else if (clr_i) begin
      valid_q   <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      occ_q     <= '0;
      dropped_q <= '0;
      out_q     <= '0;
    end else if (flush_i) begin
      valid_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      occ_q       <= '0;
      out_q.valid <= 1'b0;
    end else begin
      if (pop) begin
        valid_q[head_q]      <= 1'b0;
        head_q               <= head_q + 1'b1;
        out_q.valid          <= 1'b1;
        out_q.pc             <= pc_q[head_q];
        out_q.target_address <= tgt_q[head_q];
      end else begin
        out_q.valid <= 1'b0;
      end
      // On a full push+pop, tail equals head: this set must win over the clear.
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      if (drop && (dropped_q != '1)) begin
        dropped_q <= dropped_q + CNT_W'(1);
      end
      occ_q <= occ_d;
    end
  end

  // Payload storage needs no reset; validity is tracked separately.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (match[i]) tgt_q[i] <= upd_target_i;
    end
    if (push) begin
      pc_q[tail_q]  <= upd_pc_i;
      tgt_q[tail_q] <= upd_target_i;
    end
  end

  assign btb_update_o = out_q;
  assign occupancy_o  = occ_q;
  assign dropped_o    = dropped_q;

endmodule

// File: tb/tb_btb_update_queue.sv
// Directed bench for btb_update_queue; a second instance with a 2-bit drop
// counter shares the stimulus to exercise counter saturation.

module tb_btb_update_queue;
  localparam int DEPTH = 4;
  localparam int VL    = riscv::VLEN;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, clr, flush, dbg, upd_valid, drain;
  logic [VL-1:0] upd_pc, upd_tgt;
  ariane_pkg::btb_update_t upd_o, upd2_o;
  logic [$clog2(DEPTH):0] occ, occ2;
  logic [7:0] dropped;
  logic [1:0] dropped2;

  int errors = 0;
  int checks = 0;

  btb_update_queue #(.DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .flush_i(flush),
    .debug_mode_i(dbg), .upd_valid_i(upd_valid), .upd_pc_i(upd_pc),
    .upd_target_i(upd_tgt), .drain_en_i(drain), .btb_update_o(upd_o),
    .occupancy_o(occ), .dropped_o(dropped)
  );

  btb_update_queue #(.DEPTH(DEPTH), .CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .flush_i(flush),
    .debug_mode_i(dbg), .upd_valid_i(upd_valid), .upd_pc_i(upd_pc),
    .upd_target_i(upd_tgt), .drain_en_i(drain), .btb_update_o(upd2_o),
    .occupancy_o(occ2), .dropped_o(dropped2)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic v, input logic [VL-1:0] pc, input logic [VL-1:0] tgt);
    upd_valid = v;
    upd_pc    = pc;
    upd_tgt   = tgt;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 0; flush = 0; dbg = 0; drain = 0;
    upd(0, '0, '0);
    #12;
    checks++; if (occ !== '0) begin errors++; $display("FAIL reset_occ: got %0d want 0", occ); end
    checks++; if (upd_o !== '0) begin errors++; $display("FAIL reset_out: got %h want 0", upd_o); end
    checks++; if (dropped !== '0) begin errors++; $display("FAIL reset_dropped: got %0d want 0", dropped); end
    @(negedge clk); rst_n = 1'b1;
    cyc();
    upd(1, 'h70, 'h700);
    cyc();
    upd(0, '0, '0);
    checks++; if (occ !== 1) begin errors++; $display("FAIL clr_pre_occ: got %0d want 1", occ); end
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    checks++; if (occ !== 0) begin errors++; $display("FAIL clr_occ: got %0d want 0", occ); end
    $display("test_reset done");
  endtask

  task automatic test_latency();
    drain = 1'b1;
    upd(1, 'h80, 'h200);
    cyc();
    upd(0, '0, '0);
    checks++; if (occ !== 1) begin errors++; $display("FAIL lat_occ1: got %0d want 1", occ); end
    checks++; if (upd_o.valid !== 1'b0) begin errors++; $display("FAIL lat_early: got %b want 0", upd_o.valid); end
    cyc();
    checks++; if (upd_o !== {1'b1, VL'('h80), VL'('h200)}) begin errors++; $display("FAIL lat_out: got %h want valid pc=80 tgt=200", upd_o); end
    checks++; if (occ !== 0) begin errors++; $display("FAIL lat_occ0: got %0d want 0", occ); end
    cyc();
    checks++; if (upd_o.valid !== 1'b0 || upd_o.pc !== VL'('h80)) begin errors++; $display("FAIL lat_one_cycle: got %h want invalid pc=80", upd_o); end
    drain = 1'b0;
    $display("test_latency done");
  endtask

  task automatic test_coalesce();
    upd(1, 'h10, 'h111); cyc();
    upd(1, 'h20, 'h222); cyc();
    upd(1, 'h10, 'h999); cyc();
    upd(0, '0, '0);
    checks++; if (occ !== 2) begin errors++; $display("FAIL coal_occ: got %0d want 2", occ); end
    drain = 1'b1;
    cyc();
    checks++; if (upd_o !== {1'b1, VL'('h10), VL'('h999)}) begin errors++; $display("FAIL coal_first: got %h want pc=10 tgt=999", upd_o); end
    cyc();
    checks++; if (upd_o !== {1'b1, VL'('h20), VL'('h222)}) begin errors++; $display("FAIL coal_second: got %h want pc=20 tgt=222", upd_o); end
    cyc();
    checks++; if (upd_o.valid !== 1'b0 || occ !== 0) begin errors++; $display("FAIL coal_empty: got v=%b occ=%0d want 0/0", upd_o.valid, occ); end
    drain = 1'b0;
    $display("test_coalesce done");
  endtask

  task automatic test_overflow();
    logic [VL-1:0] exp_pc [4];
    exp_pc[0] = 'h104; exp_pc[1] = 'h108; exp_pc[2] = 'h10C; exp_pc[3] = 'h300;
    do_reset();
    for (int i = 0; i < DEPTH + 3; i++) begin
      upd(1, VL'('h100 + 4 * i), VL'('h1000 + i));
      cyc();
    end
    upd(0, '0, '0);
    checks++; if (occ !== 4) begin errors++; $display("FAIL ovf_occ: got %0d want 4", occ); end
    checks++; if (dropped !== 3) begin errors++; $display("FAIL ovf_dropped: got %0d want 3", dropped); end
    checks++; if (dropped2 !== 3) begin errors++; $display("FAIL ovf_dropped2: got %0d want 3", dropped2); end
    for (int i = 7; i < 9; i++) begin
      upd(1, VL'('h100 + 4 * i), VL'('h1000 + i));
      cyc();
    end
    upd(0, '0, '0);
    checks++; if (dropped !== 5) begin errors++; $display("FAIL ovf_dropped5: got %0d want 5", dropped); end
    checks++; if (dropped2 !== 3) begin errors++; $display("FAIL sat_dropped2: got %0d want 3", dropped2); end
    upd(1, 'h300, 'h3000);
    drain = 1'b1;
    cyc();
    upd(0, '0, '0);
    checks++; if (occ !== 4) begin errors++; $display("FAIL full_pushpop_occ: got %0d want 4", occ); end
    checks++; if (upd_o !== {1'b1, VL'('h100), VL'('h1000)}) begin errors++; $display("FAIL full_pushpop_out: got %h want pc=100 tgt=1000", upd_o); end
    checks++; if (dropped !== 5) begin errors++; $display("FAIL full_pushpop_drop: got %0d want 5", dropped); end
    for (int k = 0; k < 4; k++) begin
      cyc();
      checks++;
      if (upd_o.valid !== 1'b1 || upd_o.pc !== exp_pc[k]) begin
        errors++; $display("FAIL ovf_drain%0d: got v=%b pc=%h want 1/%h", k, upd_o.valid, upd_o.pc, exp_pc[k]);
      end
    end
    drain = 1'b0;
    cyc();
    checks++; if (occ !== 0 || upd_o.valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got occ=%0d v=%b want 0/0", occ, upd_o.valid); end
    $display("test_overflow done");
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) begin
      upd(1, VL'('h500 + 4 * i), VL'('h5000 + i));
      cyc();
    end
    upd(0, '0, '0);
    drain = 1'b1;
    cyc();
    checks++; if (occ !== 3 || upd_o.valid !== 1'b1) begin errors++; $display("FAIL flush_pre: got occ=%0d v=%b want 3/1", occ, upd_o.valid); end
    flush = 1'b1;
    upd(1, 'h5F0, 'h5F00);
    cyc();
    flush = 1'b0;
    upd(0, '0, '0);
    checks++; if (occ !== 0) begin errors++; $display("FAIL flush_occ: got %0d want 0", occ); end
    checks++; if (upd_o.valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", upd_o.valid); end
    checks++; if (dropped !== 5) begin errors++; $display("FAIL flush_dropped: got %0d want 5", dropped); end
    cyc();
    checks++; if (upd_o.valid !== 1'b0 || occ !== 0) begin errors++; $display("FAIL flush_nostore: got v=%b occ=%0d want 0/0", upd_o.valid, occ); end
    drain = 1'b0;
    $display("test_flush done");
  endtask

  task automatic test_debug();
    upd(1, 'h40, 'hA0); cyc();
    upd(1, 'h44, 'hA4); cyc();
    dbg = 1'b1;
    upd(1, 'h40, 'hFF); cyc();
    upd(1, 'h48, 'hA8); cyc();
    checks++; if (occ !== 2) begin errors++; $display("FAIL dbg_occ: got %0d want 2", occ); end
    upd(1, 'h4C, 'hAC);
    drain = 1'b1;
    cyc();
    checks++; if (upd_o !== {1'b1, VL'('h40), VL'('hA0)}) begin errors++; $display("FAIL dbg_first: got %h want pc=40 tgt=A0", upd_o); end
    cyc();
    checks++; if (upd_o !== {1'b1, VL'('h44), VL'('hA4)}) begin errors++; $display("FAIL dbg_second: got %h want pc=44 tgt=A4", upd_o); end
    cyc();
    checks++; if (upd_o.valid !== 1'b0 || occ !== 0) begin errors++; $display("FAIL dbg_empty: got v=%b occ=%0d want 0/0", upd_o.valid, occ); end
    dbg = 1'b0; drain = 1'b0;
    upd(0, '0, '0);
    $display("test_debug done");
  endtask

  task automatic test_back_to_back();
    drain = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) upd(1, VL'('hC0 + 4 * i), VL'('hD0 + i));
      else upd(0, '0, '0);
      cyc();
      checks++;
      if (i == 0) begin
        if (upd_o.valid !== 1'b0 || occ !== 1) begin errors++; $display("FAIL b2b_%0d: got v=%b occ=%0d want 0/1", i, upd_o.valid, occ); end
      end else if (i < 4) begin
        if (upd_o.valid !== 1'b1 || upd_o.pc !== VL'('hC0 + 4 * (i - 1)) || occ !== ((i == 3) ? 0 : 1)) begin
          errors++; $display("FAIL b2b_%0d: got v=%b pc=%h occ=%0d want 1/%h", i, upd_o.valid, upd_o.pc, occ, 'hC0 + 4 * (i - 1));
        end
      end else begin
        if (upd_o.valid !== 1'b0) begin errors++; $display("FAIL b2b_%0d: got v=%b want 0", i, upd_o.valid); end
      end
    end
    drain = 1'b0;
    $display("test_back_to_back done");
  endtask

  task automatic test_pop_match();
    upd(1, 'h60, 'h600); cyc();
    drain = 1'b1;
    upd(1, 'h60, 'h666); cyc();
    upd(0, '0, '0);
    checks++; if (upd_o !== {1'b1, VL'('h60), VL'('h600)} || occ !== 1) begin errors++; $display("FAIL popmatch_first: got %h occ=%0d want pc=60 tgt=600 occ=1", upd_o, occ); end
    cyc();
    checks++; if (upd_o !== {1'b1, VL'('h60), VL'('h666)} || occ !== 0) begin errors++; $display("FAIL popmatch_second: got %h occ=%0d want pc=60 tgt=666 occ=0", upd_o, occ); end
    drain = 1'b0;
    cyc();
    $display("test_pop_match done");
  endtask

  task automatic test_async_reset();
    upd(1, 'h70, 'h700); cyc();
    upd(1, 'h74, 'h704); cyc();
    upd(0, '0, '0);
    drain = 1'b1;
    cyc();
    checks++; if (upd_o.valid !== 1'b1 || dropped !== 5) begin errors++; $display("FAIL arst_pre: got v=%b dropped=%0d want 1/5", upd_o.valid, dropped); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (upd_o !== '0 || occ !== 0 || dropped !== 0) begin errors++; $display("FAIL arst: got out=%h occ=%0d dropped=%0d want zeros", upd_o, occ, dropped); end
    checks++; if (dropped2 !== 0 || occ2 !== 0) begin errors++; $display("FAIL arst_sat: got dropped=%0d occ=%0d want 0/0", dropped2, occ2); end
    drain = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    $display("test_async_reset done");
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_latency();
    test_coalesce();
    test_overflow();
    test_flush();
    test_debug();
    test_back_to_back();
    test_pop_match();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
